// File: rtl/crypto_resp_pkg.sv
// Shared constants, state encoding and rotate helper for the crypto responder core.
// Pure declarations: no latency, no flow control.
package crypto_resp_pkg;

    localparam int DATA_W   = 128;
    localparam int RND_W    = 8;
    localparam int ROTATE   = 7;
    localparam int KEY_STEP = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Doubling the word and keeping the upper half gives a rotate without a variable right shift.
    function automatic logic [DATA_W-1:0] rotl128(input logic [DATA_W-1:0] x, input logic [6:0] amt);
        logic [2*DATA_W-1:0] w_dbl;
        w_dbl = {x, x} << amt;
        return w_dbl[2*DATA_W-1:DATA_W];
    endfunction

endpackage

// File: rtl/crypto_resp_if.sv
// Request/response bundle between a crypto requester (master) and the responder core (slave).
// Level signals only; start is honoured solely while ready is high.
interface crypto_resp_if;
    import crypto_resp_pkg::*;

    logic              start;
    logic [DATA_W-1:0] key;
    logic [DATA_W-1:0] pt;
    logic [DATA_W-1:0] ct;
    logic              ready;
    logic              busy;
    logic              done;
    logic              trigger;

    modport master (output start, key, pt, input ct, ready, busy, done, trigger);
    modport slave  (input start, key, pt, output ct, ready, busy, done, trigger);

endinterface

// File: rtl/crypto_resp_round.sv
// One cipher round: rotl(state ^ rotl(key, 8*rnd mod 128), 7) ^ rnd.
// Combinational, zero latency, no flow control.
module crypto_resp_round
    import crypto_resp_pkg::*;
(
    input  logic [DATA_W-1:0] i_state,
    input  logic [DATA_W-1:0] i_key,
    input  logic [RND_W-1:0]  i_rnd,
    output logic [DATA_W-1:0] o_state_next
);

    logic [6:0]        w_kamt;
    logic [DATA_W-1:0] w_rk;

    // Truncation to 7 bits is the mod-128 of the key schedule.
    assign w_kamt       = 7'(32'(i_rnd) * KEY_STEP);
    assign w_rk         = rotl128(i_key, w_kamt);
    assign o_state_next = rotl128(i_state ^ w_rk, 7'(ROTATE)) ^ {{(DATA_W-RND_W){1'b0}}, i_rnd};

endmodule

// File: rtl/crypto_resp_core.sv
// Iterative 128-bit test cipher responder; done rises ROUNDS+1 edges after the accepting start.
// start is ignored while busy. CRYPTO_RESP_TRIGGER_EN builds a registered trigger high during ROUND.
module crypto_resp_core
    import crypto_resp_pkg::*;
#(
    parameter int TEXT_WIDTH = 128,
    parameter int KEY_WIDTH  = 128,
    parameter int ROUNDS     = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    crypto_resp_if.slave   bus
);

    localparam logic [RND_W-1:0] LP_ROUNDS = RND_W'(ROUNDS);

    state_t                r_fsm;
    state_t                w_fsm_nxt;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_ready_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;
    logic [KEY_WIDTH-1:0]  r_key;
    logic [TEXT_WIDTH-1:0] r_state;
    logic [TEXT_WIDTH-1:0] r_ct;
    logic [RND_W-1:0]      r_rnd;
    logic [DATA_W-1:0]     w_state_nxt;
    logic                  w_accept;
    logic                  w_last;

    assign w_accept = bus.start && ((r_fsm == ST_IDLE) || (r_fsm == ST_DONE));
    assign w_last   = (r_rnd == LP_ROUNDS);

    crypto_resp_round u_round (
        .i_state      (r_state),
        .i_key        (r_key),
        .i_rnd        (r_rnd),
        .o_state_next (w_state_nxt)
    );

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            ST_IDLE:  if (bus.start) w_fsm_nxt = ST_LOAD;
            ST_LOAD:  w_fsm_nxt = ST_ROUND;
            ST_ROUND: if (w_last) w_fsm_nxt = ST_DONE;
            ST_DONE:  if (bus.start) w_fsm_nxt = ST_LOAD;
            default:  w_fsm_nxt = ST_IDLE;
        endcase
        // Handshake outputs are registered decodes of the state being entered.
        w_ready_nxt = (w_fsm_nxt == ST_IDLE) || (w_fsm_nxt == ST_DONE);
        w_busy_nxt  = (w_fsm_nxt == ST_LOAD) || (w_fsm_nxt == ST_ROUND);
        w_done_nxt  = (w_fsm_nxt == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm   <= ST_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_fsm   <= w_fsm_nxt;
            r_ready <= w_ready_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key   <= '0;
            r_state <= '0;
            r_rnd   <= '0;
            r_ct    <= '0;
        end else if (w_accept) begin
            r_key   <= bus.key;
            r_state <= bus.pt ^ bus.key;
            r_rnd   <= RND_W'(1);
        end else if (r_fsm == ST_ROUND) begin
            r_state <= w_state_nxt;
            r_rnd   <= r_rnd + RND_W'(1);
            if (w_last) r_ct <= w_state_nxt;
        end
    end

    assign bus.ct    = r_ct;
    assign bus.ready = r_ready;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;

`ifdef CRYPTO_RESP_TRIGGER_EN
    logic r_trigger;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_trigger <= 1'b0;
        else        r_trigger <= (w_fsm_nxt == ST_ROUND);
    end

    assign bus.trigger = r_trigger;
`else
    assign bus.trigger = 1'b0;
`endif

endmodule

// File: tb/tb_crypto_resp_core.sv
// Directed-plus-random bench for crypto_resp_core with ROUNDS=1 and ROUNDS=10 instances
// checked against a loop-based reference of the cipher.
module tb_crypto_resp_core;

    logic         clk;
    logic         rst_n;
    logic         st1;
    logic         st10;
    logic [127:0] key_v;
    logic [127:0] pt_v;
    int           errors;
    int           checks;

    crypto_resp_if bus1 ();
    crypto_resp_if bus10 ();

    assign bus1.start  = st1;
    assign bus1.key    = key_v;
    assign bus1.pt     = pt_v;
    assign bus10.start = st10;
    assign bus10.key   = key_v;
    assign bus10.pt    = pt_v;

    crypto_resp_core #(.TEXT_WIDTH(128), .KEY_WIDTH(128), .ROUNDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));
    crypto_resp_core #(.TEXT_WIDTH(128), .KEY_WIDTH(128), .ROUNDS(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .bus(bus10));

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef CRYPTO_RESP_TRIGGER_EN
    localparam bit TRIG_BUILT = 1'b1;
`else
    localparam bit TRIG_BUILT = 1'b0;
`endif

    function automatic logic [127:0] m_rotl(input logic [127:0] x, input int n);
        int s;
        s = n % 128;
        if (s == 0) return x;
        return (x << s) | (x >> (128 - s));
    endfunction

    function automatic logic [127:0] model(input logic [127:0] k, input logic [127:0] p, input int rounds);
        logic [127:0] s;
        s = p ^ k;
        for (int i = 1; i <= rounds; i++)
            s = m_rotl(s ^ m_rotl(k, 8 * i), 7) ^ 128'(i % 256);
        return s;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start on one instance, then count edges until done and trigger-high cycles.
    task automatic op(input bit big, input logic [127:0] k, input logic [127:0] p,
                      output int lat, output int trig);
        key_v = k;
        pt_v  = p;
        if (big) st10 = 1'b1; else st1 = 1'b1;
        tick();
        st1  = 1'b0;
        st10 = 1'b0;
        chk("busy_after_accept", 128'(big ? bus10.busy : bus1.busy), 128'(1));
        chk("ready_after_accept", 128'(big ? bus10.ready : bus1.ready), 128'(0));
        lat  = -1;
        trig = 0;
        for (int e = 1; e <= 300; e++) begin
            tick();
            if (big ? bus10.trigger : bus1.trigger) trig++;
            if (big ? bus10.done : bus1.done) begin
                lat = e;
                break;
            end
        end
    endtask

    initial begin
        int           lat;
        int           trig;
        int           e;
        int           seen;
        logic [127:0] k1, p1, k2, p2;

        errors = 0;
        checks = 0;
        st1    = 1'b0;
        st10   = 1'b0;
        key_v  = '0;
        pt_v   = '0;
        rst_n  = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ct1", bus1.ct, 128'(0));
        chk("rst_ready1", 128'(bus1.ready), 128'(1));
        chk("rst_busy1", 128'(bus1.busy), 128'(0));
        chk("rst_done1", 128'(bus1.done), 128'(0));
        chk("rst_trig1", 128'(bus1.trigger), 128'(0));
        chk("rst_ct10", bus10.ct, 128'(0));
        chk("rst_ready10", 128'(bus10.ready), 128'(1));
        chk("rst_busy10", 128'(bus10.busy), 128'(0));
        chk("rst_done10", 128'(bus10.done), 128'(0));
        chk("rst_trig10", 128'(bus10.trigger), 128'(0));
        #2 rst_n = 1'b1;
        tick();

        op(1'b0, 128'h0, 128'h0, lat, trig);
        chk("zero_lat", 128'(lat), 128'(2));
        chk("zero_ct", bus1.ct, 128'h1);
        chk("zero_ready", 128'(bus1.ready), 128'(1));
        chk("zero_busy", 128'(bus1.busy), 128'(0));

        op(1'b0, 128'h0, 128'h1, lat, trig);
        chk("bit_lat", 128'(lat), 128'(2));
        chk("bit_ct", bus1.ct, 128'h81);

        for (int n = 0; n < 3; n++) begin
            k1 = rnd128();
            p1 = rnd128();
            op(1'b0, k1, p1, lat, trig);
            chk("r1_lat", 128'(lat), 128'(2));
            chk("r1_ct", bus1.ct, model(k1, p1, 1));
            k1 = rnd128();
            p1 = rnd128();
            op(1'b1, k1, p1, lat, trig);
            chk("r10_lat", 128'(lat), 128'(11));
            chk("r10_ct", bus10.ct, model(k1, p1, 10));
            chk("r10_trig_cycles", 128'(trig), TRIG_BUILT ? 128'(10) : 128'(0));
        end

        // start pulsed mid-ROUND with a different vector must be ignored.
        k1 = rnd128(); p1 = rnd128();
        k2 = rnd128(); p2 = ~p1;
        key_v = k1; pt_v = p1; st10 = 1'b1;
        tick();
        st10 = 1'b0;
        key_v = k2; pt_v = p2;
        repeat (4) tick();
        st10 = 1'b1;
        tick();
        st10 = 1'b0;
        e = 5;
        while (!bus10.done && e < 300) begin
            tick();
            e++;
        end
        chk("busy_start_lat", 128'(e), 128'(11));
        chk("busy_start_ct", bus10.ct, model(k1, p1, 10));

        // Back-to-back with start held high.
        k1 = rnd128(); p1 = rnd128();
        k2 = rnd128(); p2 = rnd128();
        key_v = k1; pt_v = p1; st10 = 1'b1;
        tick();
        e = 0;
        while (!bus10.done && e < 300) begin
            tick();
            e++;
        end
        chk("b2b_first_lat", 128'(e), 128'(11));
        chk("b2b_first_ct", bus10.ct, model(k1, p1, 10));
        key_v = k2; pt_v = p2;
        tick();
        st10 = 1'b0;
        chk("b2b_done_drop", 128'(bus10.done), 128'(0));
        chk("b2b_ct_hold", bus10.ct, model(k1, p1, 10));
        e = 1;
        while (!bus10.done && e < 300) begin
            tick();
            e++;
        end
        chk("b2b_period", 128'(e), 128'(12));
        chk("b2b_second_ct", bus10.ct, model(k2, p2, 10));

        // Reset at round 5 returns to IDLE and clears ct.
        key_v = rnd128(); pt_v = rnd128(); st10 = 1'b1;
        tick();
        st10 = 1'b0;
        repeat (5) tick();
        chk("mid_busy", 128'(bus10.busy), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ct", bus10.ct, 128'(0));
        chk("mid_rst_ready", 128'(bus10.ready), 128'(1));
        chk("mid_rst_busy", 128'(bus10.busy), 128'(0));
        chk("mid_rst_done", 128'(bus10.done), 128'(0));
        chk("mid_rst_trig", 128'(bus10.trigger), 128'(0));
        #2 rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            tick();
            if (bus10.done || bus10.busy) seen++;
        end
        chk("post_rst_quiet", 128'(seen), 128'(0));
        k1 = rnd128(); p1 = rnd128();
        op(1'b1, k1, p1, lat, trig);
        chk("post_rst_lat", 128'(lat), 128'(11));
        chk("post_rst_ct", bus10.ct, model(k1, p1, 10));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
